// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the serial BCD adder/subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_CORR = 4'd6;
  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= BCD_NINE);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One-digit BCD add with nines-complement operand select and +6 decimal correction.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       sub,
  input  logic       c_in,
  output logic [3:0] s_d,
  output logic       c_out
);

  logic [3:0] bb;
  logic [4:0] t;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    bb    = sub ? (BCD_NINE - b_d) : b_d;
    t     = {1'b0, a_d} + {1'b0, bb} + {4'b0000, c_in};
    s_d   = t[3:0];
    c_out = 1'b0;
    // Sums above nine skip the six unused binary codes to land back in 0..9.
    if (t > 5'd9) begin
      s_d   = t[3:0] + BCD_CORR;
      c_out = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Multi-digit BCD adder/subtractor, one digit per clock, LSD first, with
// valid/ready on both sides and non-BCD operand detection.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_t              state;
  logic [IDXW-1:0]     idx;
  logic [4*DIGITS-1:0] a_r;
  logic [4*DIGITS-1:0] b_r;
  logic                sub_r;
  logic                carry;

  logic                operands_ok;
  logic [3:0]          cell_s;
  logic                cell_c;

  always_comb begin
    operands_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(a[4*i +: 4]) || !is_bcd_digit(b[4*i +: 4])) begin
        operands_ok = 1'b0;
      end
    end
  end

  bcd_digit_cell u_cell (
    .a_d   (a_r[4*idx +: 4]),
    .b_d   (b_r[4*idx +: 4]),
    .sub   (sub_r),
    .c_in  (carry),
    .s_d   (cell_s),
    .c_out (cell_c)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sub_r     <= 1'b0;
      carry     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            sub_r    <= sub;
            // Subtraction is A + (nines complement of B) + 1, so borrow-in inverts.
            carry    <= sub ? ~cin : cin;
            idx      <= '0;
            in_ready <= 1'b0;
            if (operands_ok) begin
              state <= RUN;
              err   <= 1'b0;
            end else begin
              state     <= DONE;
              sum       <= '0;
              cout      <= 1'b0;
              err       <= 1'b1;
              out_valid <= 1'b1;
            end
          end
        end

        RUN: begin
          sum[4*idx +: 4] <= cell_s;
          carry           <= cell_c;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            out_valid <= 1'b1;
            // In subtract mode a missing final carry means A < B + cin.
            cout      <= sub_r ? ~cell_c : cell_c;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial against a decimal-arithmetic model.
module tb_bcd_addsub_serial;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_addsub_serial #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: plain decimal arithmetic ----------------
  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic all_bcd(input logic [W-1:0] v);
    logic [3:0] d;
    for (int i = 0; i < D; i++) begin
      d = v[4*i +: 4];
      if (d > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic longint to_int(input logic [W-1:0] v);
    longint r = 0;
    logic [3:0] d;
    for (int i = D - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      r = r * 10 + longint'(d);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint n);
    logic [W-1:0] r = '0;
    longint x = n;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic ms, input logic mc,
                       output logic [W-1:0] es, output logic ec, output logic ee);
    longint m = pow10(D);
    longint r;
    if (!all_bcd(ma) || !all_bcd(mb)) begin
      es = '0; ec = 1'b0; ee = 1'b1;
    end else begin
      ee = 1'b0;
      if (!ms) begin
        r  = to_int(ma) + to_int(mb) + longint'(mc);
        ec = (r >= m);
        es = to_bcd(r % m);
      end else begin
        r  = to_int(ma) - to_int(mb) - longint'(mc);
        ec = (r < 0);
        es = to_bcd((r + m) % m);
      end
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // ---------------- one complete operation with result checks ----------------
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic tc);
    logic [W-1:0] es;
    logic ec, ee;
    int lat, exp_lat;
    model(ta, tb, ts, tc, es, ec, ee);
    exp_lat = ee ? 0 : D;

    @(negedge clk);
    a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ta; b = ~tb;  // operand changes after acceptance must not matter
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (sum !== es || cout !== ec || err !== ee) begin
      n_bad++;
      $display("FAIL %s result: got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
               name, sum, cout, err, es, ec, ee);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s handoff: got out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset state: got in_ready=%b out_valid=%b sum=%h cout=%b err=%b want 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, err);
    end
  endtask

  task automatic test_directed();
    run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0);
    run_op("add_overflow",  16'h9999, 16'h0001, 1'b0, 1'b0);
    run_op("add_cin_only",  16'h0000, 16'h0000, 1'b0, 1'b1);
    run_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 1'b0);
    run_op("sub_underflow", 16'h0000, 16'h0001, 1'b1, 1'b0);
    run_op("sub_borrow_eq", 16'h4444, 16'h4443, 1'b1, 1'b1);
  endtask

  task automatic test_invalid();
    run_op("invalid_a", 16'h12A4, 16'h0000, 1'b0, 1'b0);
    run_op("after_invalid", 16'h0001, 16'h0001, 1'b0, 1'b0);
    run_op("invalid_b_sub", 16'h5555, 16'hF000, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int k = 0; k < 40; k++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 9) == 0) rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      run_op("random", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] es, hs;
    logic ec, ee, hc, he;
    int lat;
    model(16'h0789, 16'h0456, 1'b0, 1'b1, es, ec, ee);
    @(negedge clk);
    a = 16'h0789; b = 16'h0456; sub = 1'b0; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222;  // in_valid stays high and must be ignored
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    hs = sum; hc = cout; he = err;
    n_cmp++;
    if (lat !== D || hs !== es || hc !== ec || he !== ee) begin
      n_bad++;
      $display("FAIL bp result: got lat=%0d sum=%h cout=%b err=%b want lat=%0d sum=%h cout=%b err=%b",
               lat, hs, hc, he, D, es, ec, ee);
    end
    for (int k = 0; k < 5; k++) begin
      a = rand_bcd(); b = rand_bcd();
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== hs || cout !== hc || err !== he) begin
        n_bad++;
        $display("FAIL bp hold cycle %0d: got out_valid=%b in_ready=%b sum=%h want 1 0 %h",
                 k, out_valid, in_ready, sum, hs);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q[$];
    logic         expc_q[$];
    int           acc_cyc[$];
    logic [W-1:0] es;
    logic ec, ee;
    int n_res = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b unexpected result: got sum=%h want none", sum);
        end else begin
          es = exp_q.pop_front();
          ec = expc_q.pop_front();
          if (sum !== es || cout !== ec || err !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b result: got sum=%h cout=%b err=%b want sum=%h cout=%b err=0",
                     sum, cout, err, es, ec);
          end
        end
        n_res++;
      end
      if (in_ready === 1'b1 && cyc < 30) begin
        a = rand_bcd(); b = rand_bcd(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        model(a, b, sub, cin, es, ec, ee);
        exp_q.push_back(es);
        expc_q.push_back(ec);
        acc_cyc.push_back(cyc);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (n_res < 4 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL b2b count: got %0d results, %0d pending want >=4, 0", n_res, exp_q.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_cmp++;
      if (acc_cyc[i] - acc_cyc[i-1] !== D + 2) begin
        n_bad++;
        $display("FAIL b2b period: got %0d want %0d", acc_cyc[i] - acc_cyc[i-1], D + 2);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a = 16'h8765; b = 16'h1234; sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);           // accept
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk); // digits 0 and 1 processed; idx now 2
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1 || err !== 1'b0 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL mid-run reset: got out_valid=%b sum=%h in_ready=%b want 0 0000 1",
               out_valid, sum, in_ready);
    end
    // No stray result may appear from the discarded operation.
    repeat (D + 2) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL mid-run reset stray out_valid: got %b want 0", out_valid);
      end
    end
    run_op("after_reset", 16'h4321, 16'h1111, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_invalid();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
